mod2011_reduce_seq: RTL and testbench

MOD2011_REDUCE_SEQ -- requirements
Module: mod2011_reduce_seq

---
 rtl/mod2011_pkg.sv | 15 +
 rtl/mod2011_fold.sv | 25 ++
 rtl/mod2011_reduce_seq.sv | 106 ++++++++++
 tb/tb_mod2011_reduce_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mod2011_pkg.sv
// Shared constants and FSM state type for the mod-2011 sequential reducer.
package mod2011_pkg;

    localparam int MODULUS = 2011;
    localparam int RES_W   = 11;
    localparam int CHUNK_W = 6;
    localparam int FOLD_W  = RES_W + CHUNK_W;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mod_state_t;

endpackage

// File: rtl/mod2011_fold.sv
// One Horner step: (acc*64 + chunk) mod 2011, purely combinational.
// Binary-weighted conditional subtraction of 2011*2^k, k = 6..0.
module mod2011_fold
    import mod2011_pkg::*;
(
    input  logic [RES_W-1:0]   acc_i,
    input  logic [CHUNK_W-1:0] chunk_i,
    output logic [RES_W-1:0]   res_o
);

    logic [FOLD_W-1:0] rem;

    // The 2011*64 stage makes the reduction exact for any 17-bit input, not only acc < 2011.
    always_comb begin
        // NOTE: blocking '=' here so each subtraction stage sees the previous stage's result.
        rem = {acc_i, chunk_i};
        for (int k = 6; k >= 0; k--) begin
            if (rem >= FOLD_W'(MODULUS << k)) begin
                rem = rem - FOLD_W'(MODULUS << k);
            end
        end
        res_o = rem[RES_W-1:0];
    end

endmodule

// File: rtl/mod2011_reduce_seq.sv
// Sequential in_data mod 2011 via 6-bit Horner steps (IDLE -> RUN x N -> DONE).
// Optional output res_zero when MOD2011_ZERO_FLAG_EN is defined.
module mod2011_reduce_seq
    import mod2011_pkg::*;
#(
    parameter int OPERAND_W = 48,
    parameter int CHUNK_W   = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OPERAND_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [RES_W-1:0]     out_res,
`ifdef MOD2011_ZERO_FLAG_EN
    output logic                 res_zero,
`endif
    output logic                 busy
);

    localparam int N     = OPERAND_W / CHUNK_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    if (CHUNK_W != mod2011_pkg::CHUNK_W) begin : g_bad_chunk
        $error("mod2011_reduce_seq: CHUNK_W must be 6");
    end
    if (OPERAND_W <= 0 || (OPERAND_W % CHUNK_W) != 0) begin : g_bad_operand
        $error("mod2011_reduce_seq: OPERAND_W must be a positive multiple of 6");
    end

    mod_state_t           state_q, state_d;
    logic [OPERAND_W-1:0] opr_q, opr_d;
    logic [RES_W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [RES_W-1:0]     fold_res;

    mod2011_fold u_fold (
        .acc_i   (acc_q),
        .chunk_i (opr_q[OPERAND_W-1 -: CHUNK_W]),
        .res_o   (fold_res)
    );

    // Handshake outputs depend on state only, never on in_valid/out_ready.
    always_comb begin
        state_d   = state_q;
        opr_d     = opr_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_res   = '0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    opr_d   = in_data;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = fold_res;
                opr_d = opr_q << CHUNK_W;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                out_res   = acc_q;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking '<=' so every register samples pre-edge values.
        if (!rst_n) begin
            state_q <= IDLE;
            opr_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            opr_q   <= opr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q != IDLE);

`ifdef MOD2011_ZERO_FLAG_EN
    assign res_zero = out_valid && (out_res == '0);
`else
    // Zero flag not built; res_zero port is absent.
`endif

endmodule

// File: tb/tb_mod2011_reduce_seq.sv
// Scoreboard bench for mod2011_reduce_seq; reference is plain 64-bit '%' arithmetic.
module tb_mod2011_reduce_seq;

    localparam int OPERAND_W = 48;
    localparam int N         = OPERAND_W / 6;
    localparam int LAT       = N + 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [OPERAND_W-1:0] in_data = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [10:0]          out_res;
    logic                 busy;
`ifdef MOD2011_ZERO_FLAG_EN
    logic                 res_zero;
`endif

    typedef struct packed {
        logic [OPERAND_W-1:0] data;
        logic [10:0]          exp;
        int                   acc_cyc;
    } item_t;

    item_t sb[$];
    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    int    pushed = 0;
    int    taken = 0;
    int    discarded = 0;
    bit    hold_ready = 1'b0;

    mod2011_reduce_seq #(.OPERAND_W(OPERAND_W), .CHUNK_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
`ifdef MOD2011_ZERO_FLAG_EN
        .res_zero  (res_zero),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [10:0] model(input logic [OPERAND_W-1:0] d);
        longint unsigned v;
        v = 64'(d);
        return 11'(v % 64'd2011);
    endfunction

    // Offer one operand; hold in_valid until the block is ready, then log the expectation.
    task automatic send(input logic [OPERAND_W-1:0] d);
        int budget;
        budget = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) begin
            check("accept_timeout", in_ready, 1);
        end else begin
            sb.push_back('{data: d, exp: model(d), acc_cyc: cyc});
            pushed++;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int budget;
        budget = 0;
        while ((sb.size() != 0 || !in_ready) && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        check("drain_idle", in_ready, 1);
        check("drain_queue", sb.size(), 0);
    endtask

    // Monitor: owns out_ready, checks latency, stability, and result on each take.
    initial begin : monitor
        bit          seen;
        logic [10:0] held;
        item_t       item;
        seen = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 2) != 0);
            if (out_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    held = out_res;
                    if (sb.size() == 0) check("unexpected_out_valid", out_valid, 0);
                    else check("latency", 64'(cyc - sb[0].acc_cyc), LAT);
                end else begin
                    check("res_stable", out_res, held);
                end
                check("in_ready_in_done", in_ready, 0);
                if (out_ready) begin
                    if (sb.size() != 0) begin
                        item = sb.pop_front();
                        check("result", out_res, item.exp);
                        taken++;
                    end
                    seen = 1'b0;
                end
            end else begin
                seen = 1'b0;
                check("res_zero_outside_done", out_res, 0);
            end
            check("busy_vs_ready", busy, !in_ready);
`ifdef MOD2011_ZERO_FLAG_EN
            check("res_zero_flag", res_zero,
                  out_valid && sb.size() != 0 && sb[0].exp == 11'd0);
`endif
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [OPERAND_W-1:0] directed [8];
        logic [OPERAND_W-1:0] r;
        int                   budget;
        directed[0] = 48'd0;
        directed[1] = 48'd2011;
        directed[2] = 48'd2010;
        directed[3] = 48'd12345678;
        directed[4] = {OPERAND_W{1'b1}};
        directed[5] = 48'h8000_0000_0000;
        directed[6] = 48'd4022;
        directed[7] = 48'd2011 * 48'd65536 + 48'd2010;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_out_res", out_res, 0);
        rst_n = 1'b1;

        foreach (directed[i]) send(directed[i]);
        wait_drain();

        for (int i = 0; i < 40; i++) begin
            r = {$urandom(), $urandom()};
            if (i % 5 == 0) r = r >> $urandom_range(0, 40);
            send(r);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(negedge clk);
        end
        wait_drain();

        // Backpressure: result held 20 cycles, a stray in_valid pulse must be ignored.
        hold_ready = 1'b1;
        send(48'd777777);
        budget = 0;
        while (!out_valid && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        check("hold_reached_done", out_valid, 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("hold_in_ready", in_ready, 0);
            check("hold_out_valid", out_valid, 1);
            if (i == 5) begin
                in_valid = 1'b1;
                in_data  = 48'd12345;
            end else if (i == 6) begin
                in_valid = 1'b0;
            end
        end
        hold_ready = 1'b0;
        budget = 0;
        while (out_valid && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        check("released_in_ready", in_ready, 1);
        check("released_queue", sb.size(), 0);
        repeat (12) @(negedge clk);
        check("stray_not_accepted", busy, 0);

        // Reset in the 4th RUN cycle discards the operation.
        send(48'hABCD_EF01_2345);
        repeat (3) @(negedge clk);
        check("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        discarded += sb.size();
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        check("midrun_reset_in_ready", in_ready, 1);
        check("midrun_reset_out_valid", out_valid, 0);
        check("midrun_reset_busy", busy, 0);
        check("midrun_reset_out_res", out_res, 0);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("no_valid_after_reset", out_valid, 0);
        end
        send(48'd4022);
        wait_drain();

        check("all_results_taken", taken, pushed - discarded);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
